// File: rtl/din_pattern_pkg.sv
// Shared types for the pattern generator: pattern modes, FSM states and LFSR taps.
package din_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_INC  = 2'b00,
        MODE_DEC  = 2'b01,
        MODE_LFSR = 2'b10,
        MODE_WALK = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    // Feedback mask for x^3 + x^2 + 1: XOR of bits 2 and 1 shifts into bit 0.
    localparam logic [2:0] LFSR_TAPS = 3'b110;

endpackage

// File: rtl/lane_stepper.sv
// One data lane's next-value and seed-load logic; dir_i=1 mirrors the counting direction.
module lane_stepper
    import din_pattern_pkg::*;
#(
    parameter int LANE_W = 3
) (
    input  mode_e             mode_i,
    input  logic              dir_i,
    input  logic [LANE_W-1:0] cur_i,
    input  logic [LANE_W-1:0] seed_i,
    output logic [LANE_W-1:0] next_o,
    output logic [LANE_W-1:0] load_o
);

    localparam logic [LANE_W-1:0] TAPS = LANE_W'(LFSR_TAPS);
    localparam logic [LANE_W-1:0] ONE  = LANE_W'(1);

    logic [LANE_W-1:0] plus1;
    logic [LANE_W-1:0] minus1;

    assign plus1  = cur_i + ONE;
    assign minus1 = cur_i - ONE;

    always_comb begin
        next_o = cur_i;
        case (mode_i)
            MODE_INC:  next_o = dir_i ? minus1 : plus1;
            MODE_DEC:  next_o = dir_i ? plus1 : minus1;
            MODE_LFSR: next_o = {cur_i[LANE_W-2:0], ^(cur_i & TAPS)};
            MODE_WALK: next_o = {cur_i[LANE_W-2:0], cur_i[LANE_W-1]};
            default:   next_o = cur_i;
        endcase
    end

    // LFSR and walking-one would lock up on an all-zero lane.
    assign load_o = ((mode_i == MODE_LFSR || mode_i == MODE_WALK) && seed_i == '0) ? ONE : seed_i;

endmodule

// File: rtl/din_pattern_gen.sv
// Burst pattern generator: two registered lanes stepped per accepted beat under valid/ready.
// state  | meaning
// S_IDLE | waiting for start; beat_cnt holds the last burst's count
// S_RUN  | presenting beats, valid=1, busy=1
// S_DONE | one-cycle done pulse, then back to S_IDLE
module din_pattern_gen
    import din_pattern_pkg::*;
#(
    parameter int LANE_W = 3,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [LANE_W-1:0] seed1,
    input  logic [LANE_W-1:0] seed2,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic              ready,
    output logic [LANE_W-1:0] din1,
    output logic [LANE_W-1:0] din2,
    output logic              valid,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  beat_cnt
);

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d, mode_sel;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LANE_W-1:0] din1_q, din1_d, din2_q, din2_d;
    logic [LANE_W-1:0] next1, next2, load1, load2;
    logic [LEN_W:0]    cnt_inc, len_full;
    logic              last_beat;

    // While idle the steppers see the incoming mode so seeds are conditioned on load.
    assign mode_sel = (state_q == S_IDLE) ? mode_e'(mode) : mode_q;

    lane_stepper #(.LANE_W(LANE_W)) u_lane1 (
        .mode_i (mode_sel),
        .dir_i  (1'b0),
        .cur_i  (din1_q),
        .seed_i (seed1),
        .next_o (next1),
        .load_o (load1)
    );

    lane_stepper #(.LANE_W(LANE_W)) u_lane2 (
        .mode_i (mode_sel),
        .dir_i  (1'b1),
        .cur_i  (din2_q),
        .seed_i (seed2),
        .next_o (next2),
        .load_o (load2)
    );

    assign cnt_inc   = {1'b0, cnt_q} + {{LEN_W{1'b0}}, 1'b1};
    assign len_full  = (len_q == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len_q};
    assign last_beat = (cnt_inc == len_full);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        din1_d  = din1_q;
        din2_d  = din2_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    mode_d  = mode_e'(mode);
                    len_d   = burst_len;
                    cnt_d   = '0;
                    din1_d  = load1;
                    din2_d  = load2;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (ready) begin
                    cnt_d = cnt_inc[LEN_W-1:0];
                    if (last_beat) begin
                        state_d = S_DONE;
                    end else begin
                        din1_d = next1;
                        din2_d = next2;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_INC;
            len_q   <= '0;
            cnt_q   <= '0;
            din1_q  <= '0;
            din2_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            din1_q  <= din1_d;
            din2_q  <= din2_d;
        end
    end

    assign din1     = din1_q;
    assign din2     = din2_q;
    assign valid    = (state_q == S_RUN);
    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign beat_cnt = cnt_q;

endmodule

// File: tb/tb_din_pattern_gen.sv
// Scoreboard bench for din_pattern_gen: expected beats queued at start, compared as accepted.
module tb_din_pattern_gen;

    logic       clk = 1'b0;
    logic       reset, start, abort, ready;
    logic [1:0] mode;
    logic [2:0] seed1, seed2;
    logic [3:0] burst_len;
    logic [2:0] din1, din2;
    logic       valid, busy, done;
    logic [3:0] beat_cnt;

    typedef struct {
        logic [2:0] d1;
        logic [2:0] d2;
        logic [3:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [7:0] seen1;

    din_pattern_gen #(.LANE_W(3), .LEN_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .mode      (mode),
        .seed1     (seed1),
        .seed2     (seed2),
        .burst_len (burst_len),
        .ready     (ready),
        .din1      (din1),
        .din2      (din2),
        .valid     (valid),
        .busy      (busy),
        .done      (done),
        .beat_cnt  (beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Maximal-length x^3+x^2+1 sequence as a lookup: 1,2,5,3,7,6,4,1...
    function automatic logic [2:0] lfsr_next(input logic [2:0] v);
        case (v)
            3'd1: return 3'd2;
            3'd2: return 3'd5;
            3'd5: return 3'd3;
            3'd3: return 3'd7;
            3'd7: return 3'd6;
            3'd6: return 3'd4;
            3'd4: return 3'd1;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [2:0] mstep(input logic [1:0] m, input logic [2:0] v, input bit rev);
        case (m)
            2'd0: return rev ? 3'(v - 3'd1) : 3'(v + 3'd1);
            2'd1: return rev ? 3'(v + 3'd1) : 3'(v - 3'd1);
            2'd2: return lfsr_next(v);
            default: return {v[1:0], v[2]};
        endcase
    endfunction

    function automatic logic [2:0] mload(input logic [1:0] m, input logic [2:0] v);
        return (m[1] && v == 3'd0) ? 3'd1 : v;
    endfunction

    // stall_beat/abort_beat/reset_beat are 0-based beat indices; -1 disables.
    task automatic burst(input logic [1:0] m, input logic [2:0] s1, input logic [2:0] s2,
                         input logic [3:0] len, input int stall_beat, input int stall_n,
                         input int abort_beat, input int reset_beat);
        int total, beat, cycles, stalled;
        logic [2:0] a, b;
        bit ending;
        total = (len == 4'd0) ? 16 : int'(len);
        a = mload(m, s1);
        b = mload(m, s2);
        for (int i = 0; i < total; i++) begin
            q.push_back('{d1: a, d2: b, cnt: 4'(i)});
            a = mstep(m, a, 1'b0);
            b = mstep(m, b, 1'b1);
        end
        seen1 = '0;
        @(negedge clk);
        start = 1'b1; mode = m; seed1 = s1; seed2 = s2; burst_len = len; ready = 1'b1;
        @(negedge clk);
        // Start stays high and configuration is scrambled while running; both must be ignored.
        mode = ~m; seed1 = ~s1; seed2 = ~s2; burst_len = len + 4'd3;
        chk("run_entry_busy", 32'(busy), 32'd1);
        beat = 0; cycles = 0; stalled = 0; ending = 1'b0;
        while (beat < total && !ending) begin
            if (cycles > 200) begin
                chk("burst_timeout", 32'(cycles), 32'd0);
                ending = 1'b1;
            end else begin
                chk("valid", 32'(valid), 32'd1);
                chk("din1", 32'(din1), 32'(q[0].d1));
                chk("din2", 32'(din2), 32'(q[0].d2));
                chk("beat_cnt", 32'(beat_cnt), 32'(q[0].cnt));
                ready = 1'b1;
                if (beat == reset_beat) begin
                    reset = 1'b1; start = 1'b0;
                    @(negedge clk);
                    reset = 1'b0;
                    chk("rst_din1", 32'(din1), 32'd0);
                    chk("rst_din2", 32'(din2), 32'd0);
                    chk("rst_flags", {valid, busy, done}, 32'd0);
                    chk("rst_cnt", 32'(beat_cnt), 32'd0);
                    q.delete();
                    return;
                end
                if (beat == abort_beat) begin
                    abort = 1'b1; start = 1'b0;
                    @(negedge clk);
                    abort = 1'b0;
                    chk("abort_flags", {valid, busy, done}, 32'd0);
                    chk("abort_cnt", 32'(beat_cnt), 32'(abort_beat));
                    @(negedge clk);
                    chk("abort_no_done", 32'(done), 32'd0);
                    q.delete();
                    return;
                end
                if (beat == stall_beat && stalled < stall_n) begin
                    ready = 1'b0;
                    stalled++;
                end else begin
                    seen1[q[0].d1] = 1'b1;
                    void'(q.pop_front());
                    beat++;
                end
                @(negedge clk);
                cycles++;
            end
        end
        start = 1'b0;
        chk("done_pulse", {valid, busy, done}, 32'b001);
        chk("final_cnt", 32'(beat_cnt), 32'(4'(total)));
        chk("queue_empty", 32'(q.size()), 32'd0);
        @(negedge clk);
        chk("idle_flags", {valid, busy, done}, 32'd0);
        chk("idle_cnt_hold", 32'(beat_cnt), 32'(4'(total)));
        q.delete();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b0;
        mode = 2'd0; seed1 = 3'd0; seed2 = 3'd0; burst_len = 4'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_outs", {din1, din2, valid, busy, done, beat_cnt}, 32'd0);

        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle_noop", {valid, busy, done}, 32'd0);

        burst(2'd0, 3'd5, 3'd2, 4'd4, -1, 0, -1, -1);
        burst(2'd1, 3'd1, 3'd6, 4'd5, 1, 3, -1, -1);
        burst(2'd2, 3'd0, 3'd5, 4'd7, -1, 0, -1, -1);
        chk("lfsr_distinct", 32'(seen1), 32'hFE);
        burst(2'd3, 3'd0, 3'd4, 4'd0, -1, 0, -1, -1);
        burst(2'd0, 3'd3, 3'd3, 4'd6, -1, 0, 2, -1);
        burst(2'd0, 3'd6, 3'd1, 4'd5, -1, 0, -1, 2);
        burst(2'd2, 3'd3, 3'd0, 4'd4, 2, 2, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/din_pattern_gen.md
DIN_PATTERN_GEN -- requirements
Module: din_pattern_gen

Interface
REQ-001 SHALL have parameter LANE_W, default 3, giving the width of each output data lane.
REQ-002 SHALL have parameter LEN_W, default 4, giving the width of the beat-count and length fields.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: begins a burst when the block is idle.
REQ-006 SHALL have port abort, input, 1 bit: terminates a burst immediately.
REQ-007 SHALL have port mode, input, 2 bits: selects the pattern; 00 increment, 01 decrement, 10 LFSR, 11 walking-one.
REQ-008 SHALL have ports seed1 and seed2, input, LANE_W each: initial values of lane 1 and lane 2.
REQ-009 SHALL have port burst_len, input, LEN_W: number of beats in a burst; 0 means 2^LEN_W.
REQ-010 SHALL have port ready, input, 1 bit: asserted by the consumer to accept a beat.
REQ-011 SHALL have ports din1 and din2, output, LANE_W each: lane data, registered.
REQ-012 SHALL have port valid, output, 1 bit: lane data is presented.
REQ-013 SHALL have port busy, output, 1 bit: high in RUN.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse when a burst completes.
REQ-015 SHALL have port beat_cnt, output, LEN_W: number of beats accepted in the current burst.

Function
REQ-016 SHALL implement FSM states IDLE, RUN and DONE.
REQ-017 SHALL, in IDLE with start=1, latch mode and burst_len, load din1=seed1 and din2=seed2, and enter RUN next cycle with valid=1 and beat_cnt=0.
REQ-018 SHALL treat a beat as transferred only in a cycle where valid&&ready.
REQ-019 SHALL hold din1, din2 and valid stable while valid=1 and ready=0.
REQ-020 SHALL, on each transfer that is not the last, advance both lanes one step and increment beat_cnt; the next beat then follows with no bubble.
REQ-021 SHALL advance lanes per mode as follows:
- increment: lane1+1, lane2-1, modulo 2^LANE_W.
- decrement: lane1-1, lane2+1, modulo 2^LANE_W.
- LFSR: Fibonacci shift with taps x^3+x^2+1 for LANE_W=3; an all-zero lane is replaced by 1 on load.
- walking-one: rotate left by 1; an all-zero lane is replaced by 1 on load.
REQ-022 SHALL, on the transfer where beat_cnt+1 equals the latched length, drop valid next cycle, enter DONE, and set beat_cnt to the final count; a length of 0 wraps to the full 2^LEN_W.
REQ-023 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-024 SHALL ignore start in RUN and DONE.
REQ-025 SHALL ignore changes to mode, seed and burst_len during a burst.
REQ-026 SHALL, on abort=1 in RUN, go to IDLE next cycle with valid=0 and no done pulse; abort has priority over a same-cycle transfer, and beat_cnt is not incremented.
REQ-027 SHALL treat abort as a no-op in IDLE and DONE.
REQ-028 SHALL keep beat_cnt at its final value in IDLE until the next start, which clears it.

Reset
REQ-029 SHALL, on reset=1 at a clk edge, set state=IDLE, din1=0, din2=0, valid=0, busy=0, done=0 and beat_cnt=0.
REQ-030 SHALL give reset priority over start, abort and any transfer, including mid-burst.

Structure
REQ-031 SHALL place the mode enum, the state enum and the LFSR tap constant in package din_pattern_pkg.
REQ-032 SHALL implement the per-lane next-value function in sub-module lane_stepper, instantiated once per lane with a direction input.

Verification
REQ-033 SHALL cover increment mode: seed1=5, seed2=2, len=4, ready=1 -> din1 5,6,7,0; din2 2,1,0,7; done one cycle after the 4th transfer; beat_cnt=4.
REQ-034 SHALL cover backpressure: ready low for 3 cycles on beat 2 -> din values held stable, no beat skipped, beat_cnt increments only on valid&&ready.
REQ-035 SHALL cover LFSR with a zero seed: seed1=0, len=7 -> din1 starts at 1, produces 7 distinct non-zero values, and does not repeat within the burst.
REQ-036 SHALL cover length wrap: burst_len=0 -> exactly 16 transfers, then done.
REQ-037 SHALL cover abort: abort on beat 3 with ready=1 -> IDLE next cycle, no done, beat_cnt=2.
REQ-038 SHALL cover reset mid-burst: reset after beat 2 -> all outputs 0 next cycle; a subsequent start runs a full fresh burst.
